freq_gate_ctrl: RTL and testbench

Gate-time sequencer and edge counter for the on-chip frequency readback path. It squares the 8-bit DDS sample stream with hysteresis and counts rising edges inside a precisely timed gate window derived from the system clock. It then latches the count as the measured frequency and optionally re-arms for continuous measurement. It replaces the half-rate gate clock with a single-clock, fully synchronous controller and hands results to the display/UART layer through a one-cycle valid strobe.

---
 rtl/freq_meas_pkg.sv | 18 +
 rtl/wave_squarer.sv | 40 ++++
 rtl/freq_gate_ctrl.sv | 138 +++++++++++++
 tb/tb_freq_gate_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meas_pkg.sv
// freq_meas_pkg: shared types and defaults for the frequency readback blocks.
// Holds the gate sequencer state encoding and the default squarer thresholds.
package freq_meas_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        GATE  = 2'd2,
        LATCH = 2'd3
    } gate_state_t;

    // Default hysteresis band around the 8-bit DDS midscale.
    localparam int unsigned SQ_THRESH_HI = 135;
    localparam int unsigned SQ_THRESH_LO = 120;

    localparam int unsigned DEF_GATE_CYCLES = 50_000_000;

endpackage

// File: rtl/wave_squarer.sv
// wave_squarer: hysteresis comparator plus registered rising-edge detector.
// Ports: clk, rst (async, active-high), sin (unsigned sample), rise (1-cycle pulse).
module wave_squarer
    import freq_meas_pkg::*;
#(
    parameter int unsigned SAMPLE_W  = 8,
    parameter int unsigned THRESH_HI = SQ_THRESH_HI,
    parameter int unsigned THRESH_LO = SQ_THRESH_LO
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sin,
    output logic                rise
);

    localparam logic [SAMPLE_W-1:0] HI = SAMPLE_W'(THRESH_HI);
    localparam logic [SAMPLE_W-1:0] LO = SAMPLE_W'(THRESH_LO);

    logic sq;
    logic sq_d;

    // Samples inside [LO, HI] hold the previous level, so
    // midscale noise narrower than the band never toggles sq.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq   <= 1'b0;
            sq_d <= 1'b0;
        end else begin
            if (sin > HI) begin
                sq <= 1'b1;
            end else if (sin < LO) begin
                sq <= 1'b0;
            end
            sq_d <= sq;
        end
    end

    assign rise = sq & ~sq_d;

endmodule

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: gate-time sequencer counting squared-sample rising edges.
// Ports: clk, rst, start, continuous, abort, sin in; busy, result, result_valid, overflow out.
module freq_gate_ctrl
    import freq_meas_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int unsigned CNT_W       = 13,
    parameter int unsigned SAMPLE_W    = 8,
    parameter int unsigned THRESH_HI   = SQ_THRESH_HI,
    parameter int unsigned THRESH_LO   = SQ_THRESH_LO
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                continuous,
    input  logic                abort,
    input  logic [SAMPLE_W-1:0] sin,
    output logic                busy,
    output logic [CNT_W-1:0]    result,
    output logic                result_valid,
    output logic                overflow
);

    localparam int unsigned      TMR_W    = $clog2(GATE_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    gate_state_t      state;
    gate_state_t      state_nxt;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pend;
    logic             pend_nxt;
    logic             rise;
    logic             gate_done;
    logic             clr;
    logic             cnt_en;
    logic             do_latch;

    wave_squarer #(
        .SAMPLE_W (SAMPLE_W),
        .THRESH_HI(THRESH_HI),
        .THRESH_LO(THRESH_LO)
    ) u_sq (
        .clk (clk),
        .rst (rst),
        .sin (sin),
        .rise(rise)
    );

    assign gate_done = (tmr == TMR_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:  if (start || continuous) state_nxt = ARM;
                ARM:   state_nxt = GATE;
                GATE:  if (gate_done) state_nxt = LATCH;
                LATCH: state_nxt = continuous ? ARM : IDLE;
            endcase
        end
    end

    always_comb begin
        clr      = 1'b0;
        cnt_en   = 1'b0;
        do_latch = 1'b0;
        unique case (state)
            IDLE:  ;
            ARM:   clr = 1'b1;
            GATE: begin
                cnt_en   = 1'b1;
                do_latch = gate_done && !abort;
            end
            LATCH: ;
        endcase
    end

    // Saturating count; a rise that would wrap marks overflow instead.
    always_comb begin
        cnt_nxt  = cnt;
        pend_nxt = pend;
        if (cnt_en && rise) begin
            if (cnt == CNT_MAX) begin
                pend_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tmr  <= '0;
            pend <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tmr  <= '0;
            pend <= 1'b0;
        end else if (cnt_en) begin
            cnt  <= cnt_nxt;
            tmr  <= tmr + TMR_W'(1);
            pend <= pend_nxt;
        end
    end

    // Outputs load on the edge into LATCH so the strobe and the
    // new result appear together, including a rise in the last GATE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            result_valid <= do_latch;
            busy         <= (state_nxt != IDLE);
            if (do_latch) begin
                result   <= cnt_nxt;
                overflow <= pend_nxt;
            end
        end
    end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// tb_freq_gate_ctrl: random and directed scoreboard bench for freq_gate_ctrl.
// Two instances (13-bit and 4-bit counters) share the same stimulus.
module tb_freq_gate_ctrl;

    localparam int G = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  sin = 8'd0;
    logic        busy13, rv13, ovf13;
    logic [12:0] res13;
    logic        busy4, rv4, ovf4;
    logic [3:0]  res4;

    freq_gate_ctrl #(.GATE_CYCLES(G), .CNT_W(13)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .abort(abort), .sin(sin), .busy(busy13), .result(res13),
        .result_valid(rv13), .overflow(ovf13)
    );

    freq_gate_ctrl #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .abort(abort), .sin(sin), .busy(busy4), .result(res4),
        .result_valid(rv4), .overflow(ovf4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int lat;
        int r13;
        int o13;
        int r4;
        int o4;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model state
    bit m_active = 0;
    int gs, ge, lat, m_cnt;
    bit cur_sq = 0, prev_sq = 0, nxt_sq = 0;
    int last_r13 = 0, last_o13 = 0, last_r4 = 0, last_o4 = 0;

    // Waveform generator state
    int kind = 0, per = 10, ph = 0;
    int hi_v = 255, lo_v = 0;
    bit cont_lvl = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit hyst(input bit cur, input logic [7:0] s);
        if (s > 8'd135) return 1'b1;
        if (s < 8'd120) return 1'b0;
        return cur;
    endfunction

    task automatic gen_sample(output logic [7:0] s);
        case (kind)
            0: begin
                s  = (ph < per / 2) ? 8'(hi_v) : 8'(lo_v);
                ph = (ph + 1) % per;
            end
            1: s = 8'($urandom_range(0, 255));
            default: s = 8'($urandom_range(120, 135));
        endcase
    endtask

    task automatic set_wave(input int k, input int p, input int h, input int l);
        kind = k;
        per  = p;
        hi_v = h;
        lo_v = l;
        ph   = $urandom_range(0, p - 1);
    endtask

    task automatic open_win(input int n);
        m_active = 1;
        gs       = n + 2;
        ge       = n + G + 1;
        lat      = n + G + 2;
        m_cnt    = 0;
    endtask

    task automatic push(input int c);
        exp_t e;
        e.lat = lat;
        e.r13 = (c > 8191) ? 8191 : c;
        e.o13 = (c > 8191) ? 1 : 0;
        e.r4  = (c > 15) ? 15 : c;
        e.o4  = (c > 15) ? 1 : 0;
        sbq.push_back(e);
        last_r13 = e.r13;
        last_o13 = e.o13;
        last_r4  = e.r4;
        last_o4  = e.o4;
    endtask

    // One clock of stimulus: check busy, advance model, drive inputs.
    task automatic step(input bit st, input bit co, input bit ab);
        logic [7:0] s;
        bit         r;
        int         n;
        @(posedge clk);
        #1;
        n = cyc;
        chk("busy13", int'(busy13), int'(m_active));
        chk("busy4", int'(busy4), int'(m_active));
        prev_sq = cur_sq;
        cur_sq  = nxt_sq;
        r       = cur_sq && !prev_sq;
        if (m_active && n >= gs && n <= ge && r) m_cnt++;
        gen_sample(s);
        sin        = s;
        start      = st;
        continuous = co;
        abort      = ab;
        if (ab) begin
            m_active = 0;
        end else begin
            if (m_active && n == ge) push(m_cnt);
            if (!m_active && (st || co)) begin
                open_win(n);
            end else if (m_active && n == lat) begin
                if (co) open_win(n);
                else m_active = 0;
            end
        end
        nxt_sq = hyst(cur_sq, s);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, cont_lvl, 1'b0);
    endtask

    task automatic do_reset(input int hold);
        logic [7:0] s;
        @(posedge clk);
        #1;
        rst        = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        abort      = 1'b0;
        #1;
        chk("rst_result13", int'(res13), 0);
        chk("rst_valid13", int'(rv13), 0);
        chk("rst_ovf13", int'(ovf13), 0);
        chk("rst_busy13", int'(busy13), 0);
        chk("rst_result4", int'(res4), 0);
        chk("rst_ovf4", int'(ovf4), 0);
        m_active = 0;
        cur_sq   = 0;
        prev_sq  = 0;
        last_r13 = 0;
        last_o13 = 0;
        last_r4  = 0;
        last_o4  = 0;
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b0;
        gen_sample(s);
        sin    = s;
        nxt_sq = hyst(1'b0, s);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (rv13 || rv4) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got strobe at cycle %0d, expected none", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("strobe_cycle", cyc, e.lat);
                    chk("valid13", int'(rv13), 1);
                    chk("valid4", int'(rv4), 1);
                    chk("result13", int'(res13), e.r13);
                    chk("overflow13", int'(ovf13), e.o13);
                    chk("result4", int'(res4), e.r4);
                    chk("overflow4", int'(ovf4), e.o4);
                end
            end else if (sbq.size() != 0 && sbq[0].lat <= cyc) begin
                e = sbq.pop_front();
                n_chk++;
                n_fail++;
                $display("FAIL missed_strobe: got none at cycle %0d, expected strobe", e.lat);
            end
        end
    end

    initial begin
        int len;
        bit st, ab;

        do_reset(3);

        // Full-scale square, period 10: expect 10
        set_wave(0, 10, 255, 0);
        step(1'b1, 1'b0, 1'b0);
        run(110);

        // Continuous: three back-to-back results
        cont_lvl = 1;
        run(250);
        cont_lvl = 0;
        run(70);

        // Inside hysteresis band: expect 0
        set_wave(0, 6, 130, 125);
        step(1'b1, 1'b0, 1'b0);
        run(105);
        set_wave(2, 2, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        run(105);

        // 100/160 period 4: expect 25 (4-bit saturates)
        set_wave(0, 4, 160, 100);
        step(1'b1, 1'b0, 1'b0);
        run(105);

        // Period 2: 50 edges, 4-bit overflows; then period 10 clears it
        set_wave(0, 2, 255, 0);
        step(1'b1, 1'b0, 1'b0);
        run(105);
        set_wave(0, 10, 255, 0);
        step(1'b1, 1'b0, 1'b0);
        run(105);

        // Abort at GATE cycle 50: no strobe, result holds
        step(1'b1, 1'b0, 1'b0);
        run(50);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("abort_hold_r13", int'(res13), last_r13);
        chk("abort_hold_o13", int'(ovf13), last_o13);
        chk("abort_hold_r4", int'(res4), last_r4);
        chk("abort_hold_o4", int'(ovf4), last_o4);
        run(5);

        // start/continuous together with abort in IDLE: stay idle
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        run(3);

        // start while busy is ignored
        set_wave(0, 8, 200, 30);
        step(1'b1, 1'b0, 1'b0);
        run(40);
        step(1'b1, 1'b0, 1'b0);
        run(70);

        // Reset mid-gate
        step(1'b1, 1'b0, 1'b0);
        run(50);
        do_reset(2);
        run(3);

        // Random traffic
        repeat (10) begin
            if ($urandom_range(0, 2) == 0) begin
                set_wave(1, 2, 0, 0);
            end else begin
                set_wave(0, $urandom_range(2, 12), $urandom_range(136, 255),
                         $urandom_range(0, 119));
            end
            cont_lvl = ($urandom_range(0, 3) == 0);
            step(1'b1, cont_lvl, 1'b0);
            len = $urandom_range(60, 260);
            for (int i = 0; i < len; i++) begin
                ab = ($urandom_range(0, 299) == 0);
                st = ($urandom_range(0, 19) == 0);
                step(st, cont_lvl, ab);
            end
        end
        cont_lvl = 0;
        run(120);

        chk("queue_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
